keypad_scan_ctrl: RTL and testbench

Sequencer for the 4x4 matrix keypad: drives the column strobes, samples the row lines, debounces a press, and hands one 4-bit key code per press to downstream logic such as the 7-segment path or game control. Sits between the board keypad pins and any consumer of key codes. Replaces free-running scan logic with a state machine and a valid strobe.

---
 rtl/keypad_pkg.sv | 28 ++
 rtl/keypad_sync.sv | 24 ++
 rtl/keypad_scan_ctrl.sv | 156 +++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Holds the scan FSM state encoding and the row priority helper.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } state_t;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam logic [NUM_ROWS-1:0] ROWS_IDLE = 4'hF;

  // Lowest active-low row index wins when several rows read low.
  function automatic logic [1:0] low_row(
    input logic [NUM_ROWS-1:0] rs
  );
    logic [1:0] idx;
    idx = '0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (!rs[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the asynchronous keypad row lines.
// Resets to the all-released pattern so no phantom press is seen.
module keypad_sync
  import keypad_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_ROWS-1:0] d,
  output logic [NUM_ROWS-1:0] q
);

  logic [NUM_ROWS-1:0] s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= ROWS_IDLE;
      q  <= ROWS_IDLE;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scan, debounce and key-code strobe.
// Define KEYPAD_REPEAT_EN for auto-repeat of key_valid while held.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES   = 1000,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_ROWS-1:0] rows,
  output logic [NUM_COLS-1:0] cols,
  output logic [3:0]          key,
  output logic                key_valid,
  output logic                key_held
);

  localparam int CMAX = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ?
                        SETTLE_CYCLES : DEBOUNCE_CYCLES;
  localparam int CW = $clog2(CMAX) + 1;

  localparam logic [CW-1:0] SETTLE_END = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] DEB_END    = CW'(DEBOUNCE_CYCLES);
  // The cycle that first sees the release already counts as one.
  localparam logic [CW-1:0] REL_END    = CW'(DEBOUNCE_CYCLES - 1);

  logic [NUM_ROWS-1:0] rs;
  state_t              state, state_n;
  logic [1:0]          col, col_n;
  logic [1:0]          row, row_n;
  logic [CW-1:0]       cnt, cnt_n, cnt_inc;
  logic [3:0]          key_n;
  logic                key_valid_n;

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES) + 1;
  localparam logic [RW-1:0] RPT_END = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rpt, rpt_n;
`endif

  keypad_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rows),
    .q   (rs)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SCAN;
      col       <= '0;
      row       <= '0;
      cnt       <= '0;
      key       <= '0;
      key_valid <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rpt       <= '0;
`endif
    end else begin
      state     <= state_n;
      col       <= col_n;
      row       <= row_n;
      cnt       <= cnt_n;
      key       <= key_n;
      key_valid <= key_valid_n;
`ifdef KEYPAD_REPEAT_EN
      rpt       <= rpt_n;
`endif
    end
  end

  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

  always_comb begin
    state_n     = state;
    col_n       = col;
    row_n       = row;
    cnt_n       = cnt;
    key_n       = key;
    key_valid_n = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rpt_n       = rpt;
`endif
    unique case (state)
      SCAN: begin
        if (cnt >= SETTLE_END) begin
          cnt_n = '0;
          if (rs != ROWS_IDLE) begin
            state_n = DEBOUNCE;
            row_n   = low_row(rs);
          end else begin
            col_n = col + 2'd1;
          end
        end else begin
          cnt_n = cnt_inc;
        end
      end
      DEBOUNCE: begin
        if (rs[row]) begin
          state_n = SCAN;
          col_n   = col + 2'd1;
          cnt_n   = '0;
        end else if (cnt >= DEB_END) begin
          state_n     = PRESSED;
          key_n       = {row, col};
          key_valid_n = 1'b1;
          cnt_n       = '0;
`ifdef KEYPAD_REPEAT_EN
          rpt_n       = '0;
`endif
        end else begin
          cnt_n = cnt_inc;
        end
      end
      PRESSED: begin
        if (rs[row]) begin
          state_n = RELEASE;
          cnt_n   = CW'(1);
        end
`ifdef KEYPAD_REPEAT_EN
        else if (rpt >= RPT_END) begin
          key_valid_n = 1'b1;
          rpt_n       = '0;
        end else begin
          rpt_n = rpt + 1'b1;
        end
`endif
      end
      RELEASE: begin
        if (!rs[row]) begin
          state_n = PRESSED;
          cnt_n   = '0;
`ifdef KEYPAD_REPEAT_EN
          rpt_n   = '0;
`endif
        end else if (cnt >= REL_END) begin
          state_n = SCAN;
          col_n   = col + 2'd1;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      default: begin
        state_n = SCAN;
        cnt_n   = '0;
      end
    endcase
  end

  assign cols     = ~(NUM_COLS'(1) << col);
  assign key_held = (state == PRESSED) || (state == RELEASE);

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: keypad matrix model, run-length
// reference model checked every cycle, plus directed literal checks.
module tb_keypad_scan_ctrl;

  localparam int SETTLE = 4;
  localparam int DEB    = 16;
  localparam int RPT    = 64;

  logic       clk;
  logic       rst;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;

  logic [15:0] pressed;
  int n_checks;
  int n_fail;
  bit chk_en;
  int pulses;
  logic [3:0] last_key;

  keypad_scan_ctrl #(
    .SETTLE_CYCLES   (SETTLE),
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_CYCLES   (RPT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rows      (rows),
    .cols      (cols),
    .key       (key),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical matrix: a pressed key pulls its row low when its column is driven.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !cols[c]) rows[r] = 1'b0;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model in terms of run lengths of the synchronized row.
  int         m_mode;  // 0 scanning, 1 qualifying press, 2 key held
  logic [3:0] m_s1, m_s2, m_rs;
  int         m_col, m_row, m_t, m_lo_run, m_hi_run, m_age;
  logic [3:0] e_cols, e_key;
  logic       e_kv, e_held;

  always @(posedge clk) begin
    m_rs = m_s2;
    if (rst) begin
      m_s1 = 4'hF; m_s2 = 4'hF;
      m_mode = 0; m_col = 0; m_row = 0; m_t = 0;
      m_lo_run = 0; m_hi_run = 0; m_age = 0;
      e_key = 4'h0; e_kv = 1'b0;
    end else begin
      m_s2 = m_s1;
      m_s1 = rows;
      e_kv = 1'b0;
      if (m_mode == 0) begin
        m_t++;
        if (m_t == SETTLE) begin
          m_t = 0;
          if (m_rs != 4'hF) begin
            m_row = 3;
            for (int i = 3; i >= 0; i--) if (!m_rs[i]) m_row = i;
            m_mode = 1;
            m_lo_run = 0;
          end else m_col = (m_col + 1) % 4;
        end
      end else if (m_mode == 1) begin
        if (m_rs[m_row]) begin
          m_mode = 0; m_col = (m_col + 1) % 4; m_t = 0;
        end else begin
          m_lo_run++;
          if (m_lo_run == DEB + 1) begin
            m_mode = 2; e_key = 4'(m_row * 4 + m_col); e_kv = 1'b1;
            m_hi_run = 0; m_age = 0;
          end
        end
      end else begin
        if (m_rs[m_row]) begin
          m_hi_run++;
          if (m_hi_run == DEB) begin
            m_mode = 0; m_col = (m_col + 1) % 4; m_t = 0;
          end
        end else if (m_hi_run > 0) begin
          m_hi_run = 0; m_age = 0;
        end else begin
`ifdef KEYPAD_REPEAT_EN
          if (m_age == RPT - 1) begin
            e_kv = 1'b1; m_age = 0;
          end else m_age++;
`endif
        end
      end
    end
    e_cols = 4'hF ^ (4'h1 << m_col);
    e_held = (m_mode == 2);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cols", cols, e_cols);
      chk("key", key, e_key);
      chk("key_valid", key_valid, e_kv);
      chk("key_held", key_held, e_held);
    end
    if (key_valid === 1'b1) begin
      pulses++;
      last_key = key;
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p0;
    int k;
    bit hit;
    logic [3:0] seen;
    logic [3:0] exp_c;
    n_checks = 0; n_fail = 0; pulses = 0; last_key = 4'h0;
    chk_en = 0; rst = 1'b1; pressed = '0;

    // Reset and column rotation
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1;
    chk("rst_key", key, 4'h0);
    chk("rst_valid", key_valid, 1'b0);
    chk("rst_held", key_held, 1'b0);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      exp_c = 4'hF ^ (4'h1 << (i / 4));
      chk("rotate", cols, exp_c);
    end

    // Clean press of key 9 held for 100 cycles
    p0 = pulses;
    pressed[9] = 1'b1;
    wait_n(100);
    chk("k9_held_mid", key_held, 1'b1);
    pressed[9] = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      chk("k9_release_held", key_held, (i < 18) ? 1'b1 : 1'b0);
    end
    wait_n(20);
    chk("k9_pulses", pulses - p0, 1);
    chk("k9_code", last_key, 4'd9);
    chk("k9_key_stable", key, 4'd9);

    // Bouncing key 9: never stable for long enough
    p0 = pulses;
    for (int i = 0; i < 8; i++) begin
      pressed[9] = (i % 2 == 0);
      wait_n(5);
    end
    pressed[9] = 1'b0;
    wait_n(10);
    seen = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) if (!cols[c]) seen[c] = 1'b1;
    end
    chk("bounce_pulses", pulses - p0, 0);
    chk("bounce_scan_resumes", seen, 4'hF);
    chk("bounce_held", key_held, 1'b0);

    // Two rows low on column 3: row 0 wins
    p0 = pulses;
    pressed[3] = 1'b1;
    pressed[7] = 1'b1;
    wait_n(60);
    pressed = '0;
    wait_n(40);
    chk("two_rows_pulses", pulses - p0, 1);
    chk("two_rows_code", last_key, 4'd3);

    // Reset in the middle of debounce
    p0 = pulses;
    pressed[9] = 1'b1;
    hit = 0;
    k = 0;
    while (!hit && k < 200) begin
      @(negedge clk);
      k++;
      if (m_mode == 1 && m_lo_run == 10) hit = 1;
    end
    chk("deb_reached", hit, 1'b1);
    rst = 1'b1;
    pressed = '0;
    @(negedge clk);
    chk("midrst_cols", cols, 4'b1110);
    chk("midrst_key", key, 4'h0);
    chk("midrst_valid", key_valid, 1'b0);
    chk("midrst_held", key_held, 1'b0);
    rst = 1'b0;
    wait_n(40);
    chk("midrst_pulses", pulses - p0, 0);

    // Long hold of key 9 (auto-repeat when enabled)
    p0 = pulses;
    pressed[9] = 1'b1;
    wait_n(200);
    pressed[9] = 1'b0;
    wait_n(40);
`ifdef KEYPAD_REPEAT_EN
    chk("hold_pulses", pulses - p0, 3);
`else
    chk("hold_pulses", pulses - p0, 1);
`endif
    chk("hold_code", last_key, 4'd9);
    chk("hold_held_end", key_held, 1'b0);

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
